// File: rtl/load_access_ctrl_pkg.sv
// rtl/load_access_ctrl_pkg.sv - shared FSM state and access-size encodings for the load controller
package load_access_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_RESP  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE   = 2'd0;
    localparam logic [1:0] SIZE_HALF   = 2'd1;
    localparam logic [1:0] SIZE_WORD   = 2'd2;
    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

endpackage

// File: rtl/load_size_decode.sv
// rtl/load_size_decode.sv - one-hot size/sign decode and natural-alignment check for a load request
module load_size_decode
    import load_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [1:0] i_size,
    input  logic       i_sign,
    input  logic [2:0] i_addr_lo,
    output logic       o_is_byte,
    output logic       o_is_half,
    output logic       o_is_word,
    output logic       o_is_double,
    output logic       o_is_sign,
    output logic       o_misalign
);

    always_comb begin
        o_is_byte   = 1'b0;
        o_is_half   = 1'b0;
        o_is_word   = 1'b0;
        o_is_double = 1'b0;
        o_misalign  = 1'b0;
        o_is_sign   = i_sign;
        case (i_size)
            SIZE_BYTE: o_is_byte = 1'b1;
            SIZE_HALF: begin
                o_is_half  = 1'b1;
                o_misalign = i_addr_lo[0];
            end
            SIZE_WORD: begin
                o_is_word  = 1'b1;
                o_misalign = |i_addr_lo[1:0];
            end
            default: begin
                // a double cannot be fetched in one beat on a 32-bit bus
                o_is_double = 1'b1;
                o_misalign  = (DATA_WIDTH == 32) ? 1'b1 : (|i_addr_lo);
            end
        endcase
    end

endmodule

// File: rtl/load_access_ctrl.sv
// rtl/load_access_ctrl.sv - single-outstanding load sequencer between the pipeline, the read bus and the aligner
module load_access_ctrl
    import load_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int OFF_WIDTH  = DATA_WIDTH / 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic                  r_err,
    output logic                  ld_valid,
    input  logic                  ld_ready,
    output logic [DATA_WIDTH-1:0] pre_data,
    output logic [OFF_WIDTH:0]    data_offset,
    output logic                  is_byte,
    output logic                  is_half,
    output logic                  is_word,
    output logic                  is_double,
    output logic                  is_sign,
    output logic                  ld_misalign,
    output logic                  ld_fault
);

    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK =
        {{(ADDR_WIDTH-OFF_WIDTH-1){1'b1}}, {(OFF_WIDTH+1){1'b0}}};

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_pre_data;
    logic                  r_is_byte, r_is_half, r_is_word, r_is_double, r_is_sign;
    logic                  r_misalign, r_fault, r_flush_pend;
    logic                  w_accept;
    logic                  w_dec_byte, w_dec_half, w_dec_word, w_dec_double, w_dec_sign, w_dec_misalign;

    load_size_decode #(.DATA_WIDTH(DATA_WIDTH)) u_size_decode (
        .i_size      (req_size),
        .i_sign      (req_sign),
        .i_addr_lo   (req_addr[2:0]),
        .o_is_byte   (w_dec_byte),
        .o_is_half   (w_dec_half),
        .o_is_word   (w_dec_word),
        .o_is_double (w_dec_double),
        .o_is_sign   (w_dec_sign),
        .o_misalign  (w_dec_misalign)
    );

    assign w_accept = (r_state == ST_IDLE) && req_valid && !flush;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = w_dec_misalign ? ST_OUT : ST_ADDR;
            // an issued address must complete before the flush can take effect
            ST_ADDR:  if (ar_ready) w_next = (flush || r_flush_pend) ? ST_DRAIN : ST_RESP;
            ST_RESP: begin
                if (r_valid)    w_next = flush ? ST_IDLE : ST_OUT;
                else if (flush) w_next = ST_DRAIN;
            end
            ST_OUT:   if (flush || ld_ready) w_next = ST_IDLE;
            ST_DRAIN: if (r_valid) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE);
        ar_valid  = (r_state == ST_ADDR);
        r_ready   = (r_state == ST_RESP) || (r_state == ST_DRAIN);
        ld_valid  = (r_state == ST_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_pre_data   <= '0;
            r_is_byte    <= 1'b0;
            r_is_half    <= 1'b0;
            r_is_word    <= 1'b0;
            r_is_double  <= 1'b0;
            r_is_sign    <= 1'b0;
            r_misalign   <= 1'b0;
            r_fault      <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr      <= req_addr;
                r_is_byte   <= w_dec_byte;
                r_is_half   <= w_dec_half;
                r_is_word   <= w_dec_word;
                r_is_double <= w_dec_double;
                r_is_sign   <= w_dec_sign;
                r_misalign  <= w_dec_misalign;
                r_fault     <= 1'b0;
            end
            r_flush_pend <= (r_state == ST_ADDR) && !ar_ready && (flush || r_flush_pend);
            if ((r_state == ST_RESP) && r_valid && !flush) begin
                r_pre_data <= r_data;
                r_fault    <= r_err;
            end
        end
    end

    assign ar_addr     = r_addr & BEAT_MASK;
    assign pre_data    = r_pre_data;
    assign data_offset = r_addr[OFF_WIDTH:0];
    assign is_byte     = r_is_byte;
    assign is_half     = r_is_half;
    assign is_word     = r_is_word;
    assign is_double   = r_is_double;
    assign is_sign     = r_is_sign;
    assign ld_misalign = r_misalign && ld_valid;
    assign ld_fault    = r_fault && ld_valid;

endmodule
